// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: CDB packet type and the FU-request / broadcast bundle
package cdb_pkg;
    typedef struct packed {
        logic [3:0]  dest_ROB_entry;
        logic [31:0] result;
        logic        branch_result;
        logic        load_step1;
    } CDB_packet_t;
endpackage

interface cdb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]                    req_valid;
    cdb_pkg::CDB_packet_t [N_REQ-1:0]    req_packet;
    logic [N_REQ-1:0]                    req_yumi;
    logic                                cdb_valid;
    cdb_pkg::CDB_packet_t                cdb_out;
    logic [IDX_W-1:0]                    cdb_src;

    modport master (
        output req_valid, req_packet,
        input  req_yumi, cdb_valid, cdb_out, cdb_src
    );

    modport slave (
        input  req_valid, req_packet,
        output req_yumi, cdb_valid, cdb_out, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of FU results onto a registered common data bus
module cdb_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    logic [IDX_W-1:0] prio_ptr;
    logic [IDX_W-1:0] win;
    logic             hit;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        return IDX_W'(j >= N_REQ ? j - N_REQ : j);
    endfunction

    // scan from prio_ptr downward in priority so the nearest valid requester overrides the rest
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req_valid[rr_idx(prio_ptr, k)]) win = rr_idx(prio_ptr, k);
    end

    assign hit          = !reset && !flush && |bus.req_valid;
    assign bus.req_yumi = hit ? N_REQ'(1) << win : '0;

    // register the granted packet for broadcast and rotate priority past the winner
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_out   <= '0;
            bus.cdb_src   <= '0;
            prio_ptr      <= '0;
        end else begin
            bus.cdb_valid <= hit;
            if (hit) begin
                bus.cdb_out <= bus.req_packet[win];
                bus.cdb_src <= win;
                prio_ptr    <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for the round-robin CDB arbiter
module tb_cdb_arbiter;
    import cdb_pkg::*;

    typedef struct {
        bit          v;
        int          src;
        CDB_packet_t p;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int total = 0;
    int bad = 0;
    int mptr = 0;
    logic [3:0] pend = '0;
    CDB_packet_t [3:0] pkt = '0;
    logic [3:0] last_yumi = '0;
    exp_t q[$];

    cdb_arbiter_if #(.N_REQ(4)) bus ();

    cdb_arbiter #(.N_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // yumi must never reach an FU that is not presenting a result
    always @(posedge clk) chk("yumi_vs_valid", 64'(bus.req_yumi & ~bus.req_valid), 64'd0);

    task automatic raise_pkt(input int i, input CDB_packet_t p);
        pkt[i]  = p;
        pend[i] = 1'b1;
    endtask

    task automatic raise(input int i);
        CDB_packet_t p;
        p.dest_ROB_entry = 4'($urandom);
        p.result         = $urandom;
        p.branch_result  = 1'($urandom);
        p.load_step1     = 1'($urandom);
        raise_pkt(i, p);
    endtask

    task automatic step(input bit fl);
        exp_t e;
        int w;
        @(negedge clk);
        reset = 1'b0;
        flush = fl;
        bus.req_valid  = pend;
        bus.req_packet = pkt;
        #1;
        w = -1;
        if (!fl)
            for (int k = 0; k < 4; k++)
                if (w < 0 && pend[(mptr + k) % 4]) w = (mptr + k) % 4;
        last_yumi = bus.req_yumi;
        chk("yumi", 64'(bus.req_yumi), w < 0 ? 64'd0 : 64'd1 << w);
        e.v = w >= 0;
        e.src = w < 0 ? 0 : w;
        e.p = w < 0 ? '0 : pkt[w];
        q.push_back(e);
        if (w >= 0) begin
            pend[w] = 1'b0;
            mptr = (w + 1) % 4;
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(e.v));
        if (e.v) begin
            chk("cdb_src", 64'(bus.cdb_src), 64'(e.src));
            chk("cdb_out", 64'(bus.cdb_out), 64'(e.p));
        end
        chk("prio_ptr", 64'(dut.prio_ptr), 64'(mptr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid  = pend;
        bus.req_packet = pkt;
        #1;
        chk("yumi_in_reset", 64'(bus.req_yumi), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_cdb_out", 64'(bus.cdb_out), 64'd0);
        chk("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
        chk("rst_prio_ptr", 64'(dut.prio_ptr), 64'd0);
        mptr = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 8 && pend != 0; c++) step(1'b0);
        chk("drained", 64'(pend), 64'd0);
        step(1'b0);
    endtask

    initial begin
        bit got;
        int n;
        bus.req_valid  = '0;
        bus.req_packet = '0;
        do_reset();

        // single request from FU1
        step(1'b0);
        step(1'b0);
        raise_pkt(1, '{dest_ROB_entry: 4'd5, result: 32'h0000_0024, branch_result: 1'b0, load_step1: 1'b0});
        step(1'b0);
        chk("single_yumi", 64'(last_yumi), 64'b0010);
        step(1'b0);

        // all four valid together: expect 2,3,0,1 from prio_ptr=2
        for (int i = 0; i < 4; i++) raise(i);
        drain();

        // wrap-around: move ptr to 3, then FU0 and FU3
        raise(2);
        step(1'b0);
        raise(0);
        raise(3);
        step(1'b0);
        chk("wrap_first", 64'(last_yumi), 64'b1000);
        step(1'b0);
        chk("wrap_second", 64'(last_yumi), 64'b0001);
        chk("wrap_ptr", 64'(dut.prio_ptr), 64'd1);

        // flush while FU2 is valid with ptr=2
        raise(1);
        step(1'b0);
        raise(2);
        step(1'b1);
        chk("flush_yumi", 64'(last_yumi), 64'd0);
        step(1'b0);
        chk("post_flush_grant", 64'(last_yumi), 64'b0100);

        // starvation bound: FU0 re-raises every cycle, FU3 held
        raise(3);
        got = 1'b0;
        n = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            if (!pend[0]) raise(0);
            step(1'b0);
            n++;
            if (last_yumi[3]) got = 1'b1;
        end
        chk("starve_bound", 64'(got && n <= 4), 64'd1);
        drain();

        // reset mid-stream with a live broadcast and two FUs valid
        raise(1);
        raise(2);
        step(1'b0);
        chk("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
        raise(3);
        do_reset();
        step(1'b0);
        chk("post_rst_lowest", 64'(last_yumi), 64'b0100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
